shift_pass_sequencer: RTL



---
 rtl/shift_seq_pkg.sv | 18 +
 rtl/shift_step_calc.sv | 27 ++
 rtl/shift_pass_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and default widths for the multi-pass shift sequencer.
package shift_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CTRL_W = 3;
  localparam int DEF_AMT_W  = 5;
  localparam int DEF_PASS_W = 3;

  // Largest shift the external barrel shifter can apply in one pass.
  localparam int MAX_STEP = (1 << DEF_CTRL_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step_calc.sv
// Splits the remaining shift amount into the next barrel-shifter pass:
// step = min(rem, STEP_MAX), the remainder after it, and a last-pass flag.
module shift_step_calc
  import shift_seq_pkg::*;
#(
  parameter int AMT_W    = DEF_AMT_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int STEP_MAX = MAX_STEP
) (
  input  logic [AMT_W-1:0]  i_rem,
  output logic [CTRL_W-1:0] o_step,
  output logic [AMT_W-1:0]  o_remNext,
  output logic              o_lastPass
);

  localparam logic [AMT_W-1:0] StepMaxAmt = AMT_W'(STEP_MAX);

  logic             w_clip;
  logic [AMT_W-1:0] w_stepAmt;

  assign w_clip     = i_rem > StepMaxAmt;
  assign w_stepAmt  = w_clip ? StepMaxAmt : i_rem;
  assign o_step     = w_stepAmt[CTRL_W-1:0];
  assign o_remNext  = i_rem - w_stepAmt;
  assign o_lastPass = ~w_clip;

endmodule

// File: rtl/shift_pass_sequencer.sv
// Drives an external 8-bit barrel shifter once per cycle to apply shifts up to 31.
// Optional SHIFT_SEQ_ZERO_EXIT_EN: finish early once the operand has become zero.
module shift_pass_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int AMT_W  = DEF_AMT_W,
  parameter int PASS_W = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [DATA_W-1:0] i_req_data,
  input  logic [AMT_W-1:0]  i_req_amt,
  output logic [DATA_W-1:0] o_bs_in,
  output logic [CTRL_W-1:0] o_bs_ctrl,
  input  logic [DATA_W-1:0] i_bs_out,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [PASS_W-1:0] o_rsp_passes
);

  state_t            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [AMT_W-1:0]  r_rem;
  logic [PASS_W-1:0] r_passes;
  logic              r_rspValid;
  logic [DATA_W-1:0] r_rspData;
  logic [PASS_W-1:0] r_rspPasses;

  logic [CTRL_W-1:0] w_step;
  logic [AMT_W-1:0]  w_remNext;
  logic              w_lastPass;
  logic              w_startDone;
  logic              w_shiftDone;
  logic [PASS_W-1:0] w_passesNext;

  shift_step_calc #(
    .AMT_W    (AMT_W),
    .CTRL_W   (CTRL_W),
    .STEP_MAX ((1 << CTRL_W) - 1)
  ) u_stepCalc (
    .i_rem      (r_rem),
    .o_step     (w_step),
    .o_remNext  (w_remNext),
    .o_lastPass (w_lastPass)
  );

`ifdef SHIFT_SEQ_ZERO_EXIT_EN
  assign w_startDone = (i_req_amt == '0) || (i_req_data == '0);
  assign w_shiftDone = w_lastPass || (i_bs_out == '0);
`else
  assign w_startDone = (i_req_amt == '0);
  assign w_shiftDone = w_lastPass;
`endif

  assign w_passesNext = r_passes + PASS_W'(1);

  // The response is captured on the cycle that enters DONE so it stays frozen under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_passes    <= '0;
      r_rspValid  <= 1'b0;
      r_rspData   <= '0;
      r_rspPasses <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_acc    <= i_req_data;
            r_rem    <= i_req_amt;
            r_passes <= '0;
            if (w_startDone) begin
              r_state     <= DONE;
              r_rspValid  <= 1'b1;
              r_rspData   <= i_req_data;
              r_rspPasses <= '0;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_acc    <= i_bs_out;
          r_rem    <= w_remNext;
          r_passes <= w_passesNext;
          if (w_shiftDone) begin
            r_state     <= DONE;
            r_rspValid  <= 1'b1;
            r_rspData   <= i_bs_out;
            r_rspPasses <= w_passesNext;
          end
        end
        DONE: begin
          if (i_rsp_ready) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_bs_in      = r_acc;
  assign o_bs_ctrl    = (r_state == SHIFT) ? w_step : '0;
  assign o_rsp_valid  = r_rspValid;
  assign o_rsp_data   = r_rspData;
  assign o_rsp_passes = r_rspPasses;

endmodule
